// File: rtl/lidar_frame_streamer.sv
// lidar_frame_streamer: captures one ROWS x COLS range-image frame through a
// random-access write port and replays it in row-major order over a
// valid/ready beat interface (row, col, x, y, z, is_ground).
module lidar_frame_streamer #(
  parameter int W = 16,
  parameter int ROWS = 30,
  parameter int COLS = 30,
  parameter int ROW_W = 8,
  parameter int COL_W = 5,
  parameter logic signed [W-1:0] GROUND_Z = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [W-1:0]     wr_x,
  input  logic [W-1:0]     wr_y,
  input  logic [W-1:0]     wr_z,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [W-1:0]     out_z,
  output logic             out_is_ground
);

  localparam int NCELL = ROWS * COLS;
  localparam int ADDR_W = $clog2(NCELL + 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(NCELL);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FINISH} state_t;

  state_t state, state_nx;

  logic [3*W-1:0] mem [NCELL];
  logic [NCELL-1:0] occ;

  // Read pointer (stage p0), memory output (p1), prefetch slot (p2)
  logic [ADDR_W-1:0] rd_addr_p0;
  logic [ROW_W-1:0]  rd_row_p0;
  logic [COL_W-1:0]  rd_col_p0;
  logic              rd_en_p0;
  logic [3*W-1:0]    mem_q_p1;
  logic              occ_p1, vld_p1;
  logic [ROW_W-1:0]  row_p1;
  logic [COL_W-1:0]  col_p1;
  logic [3*W:0]      cell_p1;
  logic [3*W:0]      cell_p2;
  logic [ROW_W-1:0]  row_p2;
  logic [COL_W-1:0]  col_p2;
  logic              vld_p2;

  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              pop, out_free, last_acc, p2_load;
  logic [1:0]        cnt;

  // Zero unoccupied cells and classify ground; result is {is_ground, x, y, z}
  function automatic logic [3*W:0] fmt_cell(input logic occ_b, input logic [3*W-1:0] raw);
    logic [3*W:0] r;
    if (occ_b) r = {($signed(raw[W-1:0]) <= GROUND_Z), raw};
    else       r = {1'b1, {(3*W){1'b0}}};
    return r;
  endfunction

  assign wr_ok    = (state == IDLE) & wr_en & (wr_row <= ROW_MAX) & (wr_col <= COL_MAX);
  assign wr_addr  = ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col);
  assign mem_addr = wr_ok ? wr_addr : rd_addr_p0;

  // Beats held in output reg, prefetch slot and in-flight read; keep the total at two
  assign pop      = out_valid & out_ready;
  assign out_free = ~out_valid | out_ready;
  assign cnt      = {1'b0, out_valid} + {1'b0, vld_p1} + {1'b0, vld_p2};
  assign rd_en_p0 = ((state == PRIME) | (state == STREAM)) & (rd_addr_p0 != ADDR_END) &
                    ((cnt - {1'b0, pop}) < 2'd2);
  assign p2_load  = vld_p1 & (~out_free | vld_p2);
  assign cell_p1  = fmt_cell(occ_p1, mem_q_p1);
  assign last_acc = (state == STREAM) & pop & (out_row == ROW_MAX) & (out_col == COL_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   begin busy = 1'b1; state_nx = STREAM; end
      STREAM:  begin busy = 1'b1; if (last_acc) state_nx = FINISH; end
      FINISH:  begin busy = 1'b1; done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // Single-port frame memory: loader writes in IDLE, streamer reads otherwise
  always_ff @(posedge clk) begin
    if (wr_ok)         mem[mem_addr] <= {wr_x, wr_y, wr_z};
    else if (rd_en_p0) mem_q_p1 <= mem[mem_addr];
  end

  // Pipeline data that needs no reset: read tags (p1) and prefetch contents (p2)
  always_ff @(posedge clk) begin
    if (rd_en_p0) begin
      occ_p1 <= occ[rd_addr_p0];
      row_p1 <= rd_row_p0;
      col_p1 <= rd_col_p0;
    end
    if (p2_load) begin
      cell_p2 <= cell_p1;
      row_p2  <= row_p1;
      col_p2  <= col_p1;
    end
  end

  // Control, occupancy, read pointer, valids and the output beat register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ           <= '0;
      frame_cnt     <= '0;
      rd_addr_p0    <= '0;
      rd_row_p0     <= '0;
      rd_col_p0     <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      out_valid     <= 1'b0;
      out_row       <= '0;
      out_col       <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_z         <= '0;
      out_is_ground <= 1'b0;
    end else begin
      if (state == FINISH) begin
        occ       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (wr_ok) begin
        occ[wr_addr] <= 1'b1;
      end

      if ((state == IDLE) & start) begin
        rd_addr_p0 <= '0;
        rd_row_p0  <= '0;
        rd_col_p0  <= '0;
      end else if (rd_en_p0) begin
        rd_addr_p0 <= rd_addr_p0 + ADDR_W'(1);
        if (rd_col_p0 == COL_MAX) begin
          rd_col_p0 <= '0;
          rd_row_p0 <= rd_row_p0 + ROW_W'(1);
        end else begin
          rd_col_p0 <= rd_col_p0 + COL_W'(1);
        end
      end

      vld_p1 <= rd_en_p0;

      // ---- p1/p2 -> output register ----
      if (out_free) begin
        vld_p2 <= vld_p2 & vld_p1;
        if (vld_p2) begin
          out_valid <= 1'b1;
          out_row   <= row_p2;
          out_col   <= col_p2;
          {out_is_ground, out_x, out_y, out_z} <= cell_p2;
        end else if (vld_p1) begin
          out_valid <= 1'b1;
          out_row   <= row_p1;
          out_col   <= col_p1;
          {out_is_ground, out_x, out_y, out_z} <= cell_p1;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        vld_p2 <= vld_p2 | vld_p1;
      end
    end
  end

endmodule

// File: doc/lidar_frame_streamer.md
# lidar_frame_streamer

Frame-buffered transmitter for the range-image point stream consumed by the clustering core. The streamer captures one ROWS×COLS frame of signed 3-D points through a random-access write port. On `start`, it replays the frame in row-major order over a valid/ready interface whose fields match the clustering core's input port: row, col, x, y, z and is_ground. It sits between the sensor/host loader and the clustering input.

## Interface
- `W`, 16, coordinate width (signed two's complement)
- `ROWS`, 30, rows per frame
- `COLS`, 30, columns per frame
- `ROW_W`, 8, row index width
- `COL_W`, 5, column index width
- `GROUND_Z`, 0, signed threshold; an occupied cell with z ≤ GROUND_Z is ground
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write one cell this cycle
- `wr_row`  in  ROW_W  cell row
- `wr_col`  in  COL_W  cell column
- `wr_x`, `wr_y`, `wr_z`  in  W each  signed point coordinates
- `start`  in  1  begin streaming the stored frame (pulse)
- `busy`  out  1  streaming in progress
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `frame_cnt`  out  16  completed frames, wraps at 2^16
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_row`  out  ROW_W  beat row
- `out_col`  out  COL_W  beat column
- `out_x`, `out_y`, `out_z`  out  W each  beat coordinates (0 for unoccupied cell)
- `out_is_ground`  out  1  beat is ground/empty

## Operation
- Storage: ROWS×COLS entries of 3×W bits, single-port synchronous-read memory, address = row·COLS + col. Each entry also has an occupancy bit.
- Write rules, all in state IDLE only:
  - A `wr_en` with row < ROWS and col < COLS stores x/y/z and sets the occupancy bit.
  - Out-of-range writes are dropped.
  - `wr_en` while `busy` is dropped.
  - Rewriting the same cell overwrites it; last write wins.
- States:
  - **IDLE**: `busy`=0. `start`=1 → PRIME, and the read pointer is set to address 0.
  - **PRIME**: issue the memory read for address 0 → STREAM.
  - **STREAM**: `busy`=1. The output register holds the current beat, and one prefetch stage keeps the next beat ready. A beat transfers on `out_valid & out_ready`. After the beat for (ROWS−1, COLS−1) transfers → FINISH.
  - **FINISH**: `done`=1 for one cycle, `frame_cnt` increments, all occupancy bits clear → IDLE.
- `start` outside IDLE is ignored. `start` and `wr_en` in the same IDLE cycle: the write is performed, then streaming begins, and the written cell is visible in the stream.
- Ground: `out_is_ground` = ~occupied | (signed out_z ≤ GROUND_Z). Unoccupied cells emit x=y=z=0 with is_ground=1.
- Every cell is emitted exactly once per frame, in order (0,0),(0,1)…(0,COLS−1),(1,0)…; no cell is skipped.
- Comparison is signed at W bits; indices never exceed ROWS−1/COLS−1.

## Timing
- Reset values: `busy`=0, `done`=0, `frame_cnt`=0, `out_valid`=0, and `out_row`, `out_col`, `out_x`, `out_y`, `out_z`, `out_is_ground` all 0. State is IDLE and all occupancy bits are clear. Memory contents are don't-care.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously), the frame is abandoned, `done` does not pulse, and `frame_cnt` is unchanged from its reset value 0.
- Latency: `start` sampled at edge N → `busy`=1 from N+1 → first `out_valid`=1 at edge N+2 with cell (0,0).
- Throughput: with `out_ready` held 1, one beat per cycle, ROWS·COLS consecutive beats, no bubbles.
- Handshake:
  - Once `out_valid` rises, it stays 1 and all out_* fields stay stable until `out_ready`=1.
  - `out_valid` never depends combinationally on `out_ready`.
  - Backpressure of any length loses and duplicates no beats.
- End of frame: last beat accepted at edge M → `out_valid`=0 and `done`=1 during cycle M+1 → `busy`=0 from M+2. A new `start` is accepted from M+2 onward.
- Write visibility: a write at edge K is readable by a stream started at edge K or later.

## Test plan
- Basic frame: reset; write (2,2)=(15,15,10) and (12,12)=(75,55,60); start; `out_ready`=1.
  - Exactly 900 beats in row-major order.
  - Beat 62 = (2,2,15,15,10,ground=0); beat 372 = (12,12,75,55,60,0).
  - All other beats are (0,0,0,ground=1).
  - `done` pulses once; `frame_cnt`=1.
- Ground threshold: GROUND_Z=5; write (0,1)=(3,3,5) and (0,2)=(3,3,6) → is_ground=1 and 0 respectively.
- Backpressure: toggle `out_ready` with a pseudo-random pattern plus one 50-cycle stall mid-row.
  - Fields stay stable while valid & ~ready.
  - 900 unique beats, order intact.
- Write/start rules:
  - A write while busy to (0,0)=(9,9,9) is absent from this frame and the next.
  - A write to row 30 or col 30 is dropped.
  - `start` during busy does not restart the frame.
  - After `done`, a second start emits all-ground (occupancy cleared); `frame_cnt`=2.
- Async reset mid-stream: assert `rst` between clock edges at beat 400.
  - `out_valid`/`busy` go to 0 before the next edge.
  - After release, a fresh frame streams from (0,0); `frame_cnt`=0 until its `done`.
- Latency: `start` at edge N → `out_valid` at N+2; last accept at M → `done` at M+1, `busy`=0 at M+2.
